// File: rtl/if_fetch_queue.sv
// if_fetch_queue: issues fetches at the PC, queues in-order responses with their PCs, hands them to decode
module if_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_stall,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            flush,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_inst,
    output logic [XLEN-1:0] id_pc,
    output logic            err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] pc_mem [DEPTH];
    logic [XLEN-1:0] inst_mem [DEPTH];
    logic [DEPTH-1:0] filled;
    logic [PW-1:0] alloc_ptr, fill_ptr, head_ptr;
    logic [CW-1:0] occ, pend, drop_cnt, owed;
    logic acc, pop, fill, drop;

    // issue/stall/output handshakes; pend tracks allocated entries still awaiting data
    always_comb begin
        owed = drop_cnt + pend;
        imem_req_valid = !rst && !flush && ((occ + drop_cnt) < CW'(DEPTH));
        imem_req_addr = pc_in;
        acc = imem_req_valid && imem_req_ready;
        pc_stall = rst || (!acc && !flush);
        id_valid = !rst && !flush && filled[head_ptr];
        id_inst = inst_mem[head_ptr];
        id_pc = pc_mem[head_ptr];
        pop = id_valid && id_ready;
        drop = imem_resp_valid && !flush && (drop_cnt != '0);
        fill = imem_resp_valid && !flush && (drop_cnt == '0) && (pend != '0);
    end

    // control state: pointers, counters, filled bits and sticky error; flush outranks pop and alloc
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alloc_ptr <= '0;
            fill_ptr <= '0;
            head_ptr <= '0;
            occ <= '0;
            pend <= '0;
            drop_cnt <= '0;
            filled <= '0;
            err <= 1'b0;
        end else if (flush) begin
            alloc_ptr <= '0;
            fill_ptr <= '0;
            head_ptr <= '0;
            occ <= '0;
            pend <= '0;
            filled <= '0;
            drop_cnt <= owed - CW'(imem_resp_valid && (owed != '0));
            err <= err || (imem_resp_valid && (owed == '0));
        end else begin
            alloc_ptr <= alloc_ptr + PW'(acc);
            fill_ptr <= fill_ptr + PW'(fill);
            head_ptr <= head_ptr + PW'(pop);
            occ <= occ + CW'(acc) - CW'(pop);
            pend <= pend + CW'(acc) - CW'(fill);
            drop_cnt <= drop_cnt - CW'(drop);
            err <= err || (imem_resp_valid && !drop && !fill);
            if (acc) filled[alloc_ptr] <= 1'b0;
            if (fill) filled[fill_ptr] <= 1'b1;
            if (pop) filled[head_ptr] <= 1'b0;
        end
    end

    // payload storage needs no reset; the filled bits qualify it
    always_ff @(posedge clk) begin
        if (acc) pc_mem[alloc_ptr] <= pc_in;
        if (fill) inst_mem[fill_ptr] <= imem_resp_data;
    end
endmodule
